// File: rtl/divmmc_spi_port_pkg.sv
// Shared constants for the DivMMC SPI port: default port addresses, SPI FSM
// state encodings and the idle card-select pattern.
package divmmc_spi_port_pkg;

  localparam logic [7:0] PORT_DATA_DEF = 8'hEB;
  localparam logic [7:0] PORT_CS_DEF   = 8'hE7;
  localparam logic [1:0] SD_CS_IDLE    = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  // Strobe is a real port access only when IORQ is low outside an M1 cycle.
  function automatic logic is_io_access(input logic iorq_n, input logic m1_n,
                                        input logic rd_n, input logic wr_n);
    return !iorq_n && m1_n && (!rd_n || !wr_n);
  endfunction

endpackage

// File: rtl/divmmc_spi_port_shift8.sv
// 8-bit SPI mode-0 master, MSB first, SCLK half-period of SPI_DIV clocks.
//  state   | meaning
//  ST_IDLE | waiting for start; sclk low, mosi high
//  ST_LOW  | sclk low half of a bit; mosi holds current bit
//  ST_HIGH | sclk high half of a bit; miso already sampled
module spi_shift8
  import divmmc_spi_port_pkg::*;
#(
  parameter int SPI_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;

  // The shifter MSB is the bit on the wire; the line idles high between bytes.
  assign mosi = busy ? tx_sh[7] : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= 8'hFF;
      rx_sh   <= 8'hFF;
      rx      <= 8'hFF;
      busy    <= 1'b0;
      sclk    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sclk <= 1'b0;
          if (start) begin
            tx_sh   <= tx;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b1;
            state   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            rx_sh   <= {rx_sh[6:0], miso};
            state   <= ST_HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (bit_cnt == 3'd7) begin
              rx    <= rx_sh;
              busy  <= 1'b0;
              tx_sh <= 8'hFF;
              state <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_sh   <= {tx_sh[6:0], 1'b1};
              state   <= ST_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/divmmc_spi_port.sv
// DivMMC SD-card port responder: Z80 bus sync and decode, card-select register,
// read-back drive, and the SPI byte engine toward the socket.
module divmmc_spi_port
  import divmmc_spi_port_pkg::*;
#(
  parameter logic [7:0] PORT_DATA = PORT_DATA_DEF,
  parameter logic [7:0] PORT_CS   = PORT_CS_DEF,
  parameter int         SPI_DIV   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  output logic [1:0] sd_cs_n,
  output logic       sd_sclk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       busy
);

  logic [1:0] iorq_sy, m1_sy, rd_sy, wr_sy;
  logic       active, active_q, commit;
  logic [7:0] a_q, din_q;
  logic       wr_q;
  logic       start;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iorq_sy <= 2'b11;
      m1_sy   <= 2'b11;
      rd_sy   <= 2'b11;
      wr_sy   <= 2'b11;
    end else begin
      iorq_sy <= {iorq_sy[0], iorq_n};
      m1_sy   <= {m1_sy[0], m1_n};
      rd_sy   <= {rd_sy[0], rd_n};
      wr_sy   <= {wr_sy[0], wr_n};
    end
  end

  assign active = is_io_access(iorq_sy[1], m1_sy[1], rd_sy[1], wr_sy[1]);
  // Act once the strobe is over so address/data have been captured stable.
  assign commit = active_q && !active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      a_q      <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      sd_cs_n  <= SD_CS_IDLE;
    end else begin
      active_q <= active;
      if (active) begin
        a_q   <= a;
        din_q <= din;
        wr_q  <= !wr_sy[1];
      end
      if (commit && wr_q && (a_q == PORT_CS))
        sd_cs_n <= din_q[1:0];
    end
  end

  assign start   = commit && (a_q == PORT_DATA);
  assign tx_byte = wr_q ? din_q : 8'hFF;

  assign oe   = !iorq_n && !rd_n && m1_n && (a == PORT_DATA);
  assign dout = rx_byte;

  spi_shift8 #(.SPI_DIV(SPI_DIV)) u_spi (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .tx    (tx_byte),
    .rx    (rx_byte),
    .busy  (busy),
    .sclk  (sd_sclk),
    .mosi  (sd_mosi),
    .miso  (sd_miso)
  );

endmodule

// File: tb/tb_divmmc_spi_port.sv
// Bench for divmmc_spi_port: Z80 bus tasks, an SD-card slave model and a
// scoreboard of expected MOSI/MISO bytes per transfer.
module tb_divmmc_spi_port;

  localparam int SPI_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a;
  logic       iorq_n, m1_n, rd_n, wr_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe;
  logic [1:0] sd_cs_n;
  logic       sd_sclk, sd_mosi, busy;
  logic       sd_miso = 1'b1;

  divmmc_spi_port #(.PORT_DATA(8'hEB), .PORT_CS(8'hE7), .SPI_DIV(SPI_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .m1_n(m1_n),
    .rd_n(rd_n), .wr_n(wr_n), .din(din), .dout(dout), .oe(oe),
    .sd_cs_n(sd_cs_n), .sd_sclk(sd_sclk), .sd_mosi(sd_mosi),
    .sd_miso(sd_miso), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] tx; logic [7:0] rx; } sb_item_t;
  sb_item_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SD slave model: loads a response when a transfer starts, drives MSB
  // first, advances on falling SCLK, captures MOSI on rising SCLK.
  logic [7:0] resp = 8'hFF;
  logic [7:0] miso_sh;
  logic [7:0] mosi_cap;
  int         pulses = 0;
  int         xfer_cnt = 0;

  always @(posedge busy) begin
    pulses   = 0;
    mosi_cap = 8'h00;
    miso_sh  = resp;
    sd_miso  = resp[7];
    xfer_cnt++;
  end

  always @(posedge sd_sclk) begin
    pulses++;
    mosi_cap = {mosi_cap[6:0], sd_mosi};
  end

  always @(negedge sd_sclk) begin
    miso_sh = {miso_sh[6:0], 1'b1};
    sd_miso = miso_sh[7];
  end

  int   busy_len = 0;
  logic busy_prev = 1'b0;
  always @(posedge clk) begin
    if (busy && !busy_prev) busy_len <= 1;
    else if (busy)          busy_len <= busy_len + 1;
    busy_prev <= busy;
  end

  task automatic io_wr(input logic [7:0] addr, input logic [7:0] data, input int len);
    @(negedge clk);
    a = addr; din = data; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (len) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    a = 8'h00; din = 8'h00;
  endtask

  task automatic io_rd(input logic [7:0] addr, output logic o, output logic [7:0] d);
    @(negedge clk);
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    o = oe; d = dout;
    repeat (2) @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (4) @(negedge clk);
    a = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int t;
    sb_item_t e;
    t = 0;
    while (!busy && t < 40) begin @(negedge clk); t++; end
    check_eq({tag, "_start"}, busy, 1'b1);
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    check_eq({tag, "_end"}, busy, 1'b0);
    check_eq({tag, "_sb"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, "_mosi"}, mosi_cap, e.tx);
      check_eq({tag, "_pulses"}, pulses, 8);
      check_eq({tag, "_busylen"}, busy_len, 16 * SPI_DIV);
      check_eq({tag, "_rx"}, dout, e.rx);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic       r_oe;
  logic [7:0] r_d;
  int         xc;

  initial begin
    rst_n = 1'b0; a = 8'h00; din = 8'h00;
    iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs", sd_cs_n, 2'b11);
    check_eq("rst_sclk", sd_sclk, 1'b0);
    check_eq("rst_mosi", sd_mosi, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_dout", dout, 8'hFF);
    check_eq("rst_oe", oe, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    io_wr(8'hE7, 8'hFE, 3);
    repeat (2) @(negedge clk);
    check_eq("cs_write", sd_cs_n, 2'b10);
    check_eq("cs_no_xfer", xfer_cnt, 0);

    // Write A5, card answers 3C.
    resp = 8'h3C;
    sb.push_back('{tx: 8'hA5, rx: 8'h3C});
    io_wr(8'hEB, 8'hA5, 3);
    wait_done("wr_a5");

    // Read returns 3C and refills with FF; card answers 81.
    resp = 8'h81;
    sb.push_back('{tx: 8'hFF, rx: 8'h81});
    io_rd(8'hEB, r_oe, r_d);
    check_eq("rd_oe", r_oe, 1'b1);
    check_eq("rd_dout", r_d, 8'h3C);
    check_eq("rd_busy_dout", dout, 8'h3C);
    wait_done("rd_ff");
    check_eq("idle_oe", oe, 1'b0);

    // Second write lands while the first is still shifting and is dropped.
    resp = 8'h5E;
    xc = xfer_cnt;
    sb.push_back('{tx: 8'h11, rx: 8'h5E});
    io_wr(8'hEB, 8'h11, 1);
    io_wr(8'hEB, 8'h22, 1);
    wait_done("b2b");
    repeat (80) @(negedge clk);
    check_eq("b2b_drop", xfer_cnt - xc, 1);
    check_eq("b2b_busy", busy, 1'b0);

    // Interrupt acknowledge and a read of the card-select port do nothing.
    xc = xfer_cnt;
    @(negedge clk);
    a = 8'hEB; iorq_n = 1'b0; m1_n = 1'b0;
    @(negedge clk);
    check_eq("inta_oe", oe, 1'b0);
    repeat (2) @(negedge clk);
    iorq_n = 1'b1; m1_n = 1'b1;
    repeat (4) @(negedge clk);
    a = 8'h00;
    io_rd(8'hE7, r_oe, r_d);
    check_eq("rd_cs_oe", r_oe, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("inta_no_xfer", xfer_cnt - xc, 0);
    check_eq("inta_cs", sd_cs_n, 2'b10);

    // Reset in the middle of a transfer discards it.
    resp = 8'h42;
    io_wr(8'hEB, 8'hC3, 3);
    xc = 0;
    while (pulses < 3 && xc < 200) begin @(negedge clk); xc++; end
    check_eq("mid_pulses", pulses, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_sclk", sd_sclk, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_dout", dout, 8'hFF);
    check_eq("mid_rst_cs", sd_cs_n, 2'b11);
    @(negedge clk); rst_n = 1'b1;

    resp = 8'h96;
    sb.push_back('{tx: 8'h5A, rx: 8'h96});
    io_wr(8'hEB, 8'h5A, 3);
    wait_done("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
